// File: rtl/shift_sequencer.sv
// shift_sequencer: pattern register and advance control that sits in front of an
// external combinational shifter. Each committed advance writes the shifter output
// back into the pattern register. Advances come from a free-running tick (run) or
// from single-step pulses (step).
//
// Optional feature: define SHIFT_SEQ_BOUNCE_EN to reverse the direction whenever the
// pattern reaches the edge it is moving towards. The advance that performs the flip
// holds the pattern.
module shift_sequencer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [3:0]       i_dist_in,
  input  logic             i_dir_in,
  input  logic             i_run,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_sh_in,
  output logic [3:0]       o_sh_dist,
  output logic             o_sh_dir,
  input  logic [WIDTH-1:0] i_sh_out,
  output logic             o_adv,
  output logic             o_empty,
  output logic [7:0]       o_adv_count
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] TickMax = CntW'(TICK_DIV - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_pattern;
  logic [3:0]       r_dist;
  logic             r_dir;
  logic [CntW-1:0]  r_tick;
  logic [7:0]       r_adv_count;
  logic             r_empty;

  logic             w_commit;
  logic             w_flip;
  logic [WIDTH-1:0] w_next_pat;

  // An advance commits on the last tick in RUN or on a step in IDLE; load overrides both.
  assign w_commit = !i_load && (((r_state == StRun) && (r_tick == TickMax)) ||
                                ((r_state == StIdle) && i_step));

`ifdef SHIFT_SEQ_BOUNCE_EN
  // Pattern sits on the edge it is heading towards: this advance turns it around.
  assign w_flip = (!r_dir && r_pattern[WIDTH-1]) || (r_dir && r_pattern[0]);
`else
  assign w_flip = 1'b0;
`endif

  assign w_next_pat = w_flip ? r_pattern : i_sh_out;

  // Sequencer state, pattern register and advance bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_pattern   <= '0;
      r_dist      <= 4'd0;
      r_dir       <= 1'b0;
      r_tick      <= '0;
      r_adv_count <= 8'd0;
      r_empty     <= 1'b1;
    end else if (i_load) begin
      r_state     <= StIdle;
      r_pattern   <= i_load_val;
      r_dist      <= i_dist_in;
      r_dir       <= i_dir_in;
      r_tick      <= '0;
      r_adv_count <= 8'd0;
      r_empty     <= (i_load_val == '0);
    end else begin
      if (w_commit) begin
        r_pattern   <= w_next_pat;
        r_empty     <= (w_next_pat == '0);
        r_adv_count <= r_adv_count + 8'd1;
        if (w_flip) begin
          r_dir <= ~r_dir;
        end
      end
      unique case (r_state)
        StIdle: begin
          r_tick <= '0;
          if (i_run) begin
            r_state <= StRun;
          end
        end
        StRun: begin
          if (!i_run || (w_commit && (w_next_pat == '0))) begin
            r_state <= StIdle;
            r_tick  <= '0;
          end else if (r_tick == TickMax) begin
            r_tick <= '0;
          end else begin
            r_tick <= r_tick + CntW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
          r_tick  <= '0;
        end
      endcase
    end
  end

  assign o_sh_in     = r_pattern;
  assign o_sh_dist   = r_dist;
  assign o_sh_dir    = r_dir;
  assign o_adv       = w_commit;
  assign o_empty     = r_empty;
  assign o_adv_count = r_adv_count;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Sequencing stage that sits directly upstream of the combinational shifter. It holds the pattern register that drives the shifter's `in`, `dist` and `dir` inputs, and writes the shifter's `out` back into that register on every advance. The result is a closed loop that animates an LED pattern at a programmable tick rate, either free-running or by single-step. Loop: pattern register -> shifter (external, combinational) -> this block -> pattern register.

## Interface
- `WIDTH`, default 8: pattern width. Must match the shifter's `WIDTH`.
- `TICK_DIV`, default 25_000_000: clock cycles per automatic advance. Must be ≥ 2. The counter width is `$clog2(TICK_DIV)`.
- `clk` input, 1: the block's single clock. All state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `load` input, 1: one-cycle pulse. Loads `load_val`, `dist_in` and `dir_in`.
- `load_val` input, WIDTH: pattern value taken on `load`.
- `dist_in` input, 4: shift distance taken on `load`.
- `dir_in` input, 1: direction taken on `load`. 0 = left, 1 = right.
- `run` input, 1: level. High enables free-running advance.
- `step` input, 1: one-cycle pulse. Requests a single advance; honoured only in IDLE.
- `sh_in` output, WIDTH: drives the shifter's `in`. Always equal to the pattern register.
- `sh_dist` output, 4: drives the shifter's `dist`. Registered.
- `sh_dir` output, 1: drives the shifter's `dir`. Registered.
- `sh_out` input, WIDTH: the shifter's `out` (combinational from `sh_in`/`sh_dist`/`sh_dir`).
- `adv` output, 1: one-cycle pulse, high in the cycle an advance is committed.
- `empty` output, 1: registered. High when the pattern register is 0.
- `adv_count` output, 8: number of advances since the last `load`. Wraps 255 -> 0.

## Operation
- States: IDLE and RUN.
  - IDLE -> RUN when `run`=1 and `load`=0.
  - RUN -> IDLE when `run`=0, when `load`=1, or when an advance produces pattern 0.
- Advance: on commit, the pattern register takes `sh_out`, `adv_count` increments by 1, and `adv` is high for that cycle.
- RUN: the tick counter counts 0..TICK_DIV-1. An advance commits in the cycle the counter equals TICK_DIV-1; the counter then returns to 0.
- The tick counter is cleared on entry to RUN and while in IDLE. The first advance therefore occurs TICK_DIV cycles after the cycle in which the state becomes RUN.
- IDLE: `step`=1 commits one advance in that same cycle. `step` is ignored in RUN.
- Priority, highest first: `load`, then advance, then hold.
  - `load` loads pattern, `sh_dist` and `sh_dir`; clears `adv_count`; forces IDLE.
  - `load` suppresses any advance or `step` in the same cycle.
- Zero detect: if a committed advance writes 0, the block returns to IDLE next cycle and `empty` rises. `step` still commits while empty; the pattern stays 0.
- `dist_in` values ≥ WIDTH are passed through unmodified; the shifter defines the result.
- Reset values: pattern 0, `sh_dist` 0, `sh_dir` 0, state IDLE, tick counter 0, `adv_count` 0, `adv` 0, `empty` 1.

## Timing
- `sh_in`, `sh_dist` and `sh_dir` change only on a clock edge. `sh_out` must settle within one cycle.
- Advance latency:
  - `step` pulse: new pattern visible the cycle after the pulse.
  - RUN: one advance per TICK_DIV cycles.
- `load` -> outputs: new values are visible the cycle after the pulse.
- Reset asserted mid-RUN: all registers take reset values immediately (asynchronous). The block resumes in IDLE after `rst_n` deasserts, regardless of `run`. RUN is entered only on the first edge at which `run`=1 after deassertion.

## Configuration
- `SHIFT_SEQ_BOUNCE_EN` defined:
  - Before committing an advance, if `sh_dir`=0 and pattern[WIDTH-1]=1, `sh_dir` flips to 1.
  - Before committing an advance, if `sh_dir`=1 and pattern[0]=1, `sh_dir` flips to 0.
  - On a flip, that advance is consumed by the flip: the pattern is held, `adv` still pulses, and `adv_count` still increments. The next advance uses the new direction.
  - Result: a non-wrapping shifter ping-pongs the pattern instead of draining it.
- Not defined: `sh_dir` changes only on `load`.

## Test plan
Configuration for all scenarios: WIDTH=8, TICK_DIV=4, non-wrapping shifter attached.
- Reset: `rst_n`=0 with `run`=1 -> all outputs at reset values, `empty`=1. After release, IDLE until the next edge with `run`=1.
- Step: load 8'b0000_0001, dist 1, dir 0; three `step` pulses -> pattern 02, 04, 08; `adv_count`=3.
- Run timing: load 8'h01, dist 2, dir 0; raise `run` -> `adv` every 4 cycles; pattern 04, 10, 40, then 00. After 00: `empty`=1, state IDLE, no further `adv`.
- Priority: `load` 8'hF0 and `step` in the same cycle -> pattern F0, no `adv`, `adv_count`=0.
- `SHIFT_SEQ_BOUNCE_EN` defined: load 8'h40, dist 1, dir 0; run -> patterns 80, 80 (dir flips to 1), 40, 20.
- Reset mid-RUN with pattern 8'h10 -> pattern 00 and IDLE immediately, without waiting for a clock edge.
